// File: rtl/watchdog_pkg.sv
// Shared definitions for the windowed watchdog: config bit positions and kick FSM states.
package watchdog_pkg;

  localparam int CFG_EN    = 0;
  localparam int CFG_OVF   = 1;
  localparam int CFG_TRAP  = 2;
  localparam int CFG_VIOL  = 3;
  localparam int CFG_WIRQ  = 4;
  localparam int CFG_LOCK  = 5;
  localparam int CFG_WPEND = 6;

  typedef enum logic {
    KICK_IDLE,
    KICK_ARMED
  } kick_state_t;

endpackage

// File: rtl/wd_prescaler.sv
// Free-running prescaler that divides enabled clocks down to one counter tick
// every 2^PRESC_BITS cycles.
module wd_prescaler #(
  parameter int PRESC_BITS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [PRESC_BITS-1:0] count_q;

  // Count only while enabled; any reset source or a valid kick restarts the period.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  // The tick is gated by enable so a prescaler frozen at all-ones stays quiet.
  assign tick = en & (&count_q);

endmodule

// File: rtl/watchdog_window.sv
// Windowed watchdog with keyed kick, early-kick detection, warning interrupt and
// lock bit. Any watchdog event produces a one-cycle system reset pulse.
module watchdog_window
  import watchdog_pkg::*;
#(
  parameter int          WIDTH      = 16,
  parameter int          PRESC_BITS = 4,
  parameter int          WARN_TICKS = 16,
  parameter logic [7:0]  KEY0       = 8'h5A,
  parameter logic [7:0]  KEY1       = 8'hA5
) (
  input  logic               clk,
  input  logic               power_on_reset,
  input  logic               trap,
  output logic               reset,
  output logic               irq,
  input  logic [WIDTH-1:0]   counter_in,
  input  logic [WIDTH/8-1:0] counter_write,
  output logic [WIDTH-1:0]   counter_out,
  input  logic [WIDTH-1:0]   reload_in,
  input  logic [WIDTH/8-1:0] reload_write,
  output logic [WIDTH-1:0]   reload_out,
  input  logic [WIDTH-1:0]   window_in,
  input  logic [WIDTH/8-1:0] window_write,
  output logic [WIDTH-1:0]   window_out,
  input  logic [7:0]         kick_in,
  input  logic               kick_write,
  input  logic [7:0]         config_in,
  input  logic               config_write,
  output logic [7:0]         config_out
);

  localparam int LANES = WIDTH / 8;
  localparam logic [WIDTH-1:0] WARN_VAL = {WIDTH{1'b1}} - WIDTH'(WARN_TICKS);

  logic [WIDTH-1:0] counter_q, counter_d, counter_inc;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] window_q, window_d;
  logic [7:0]       cfg_q, cfg_d;
  kick_state_t      state_q, state_d;
  logic             fire_q, fire_ovf_q, fire_viol_q;
  logic             enabled, locked, reset_cycle, tick, presc_clr;
  logic             key_viol, kick_ok, win_viol, kick_valid, violation;
  logic             overflow, warn_hit;
  logic             unused_cfg_bit;

  assign enabled     = cfg_q[CFG_EN];
  assign locked      = cfg_q[CFG_LOCK];
  assign reset_cycle = fire_q | trap;
  assign counter_inc = counter_q + 1'b1;
  assign presc_clr   = reset_cycle | kick_valid;
  assign unused_cfg_bit = config_in[7];

  wd_prescaler #(
    .PRESC_BITS(PRESC_BITS)
  ) u_prescaler (
    .clk  (clk),
    .reset(power_on_reset),
    .en   (enabled),
    .clr  (presc_clr),
    .tick (tick)
  );

  // Kick key state register; the sequence always restarts from IDLE after power-up.
  always_ff @(posedge clk) begin
    if (power_on_reset) begin
      state_q <= KICK_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Kick sequence decoding: KEY0 arms, KEY1 kicks, anything else is a key violation.
  // The window check uses the counter value before any same-cycle tick.
  always_comb begin
    state_d  = state_q;
    key_viol = 1'b0;
    kick_ok  = 1'b0;
    if (!enabled || reset_cycle) begin
      state_d = KICK_IDLE;
    end else if (kick_write) begin
      case (state_q)
        KICK_IDLE: begin
          if (kick_in == KEY0) state_d = KICK_ARMED;
          else                 key_viol = 1'b1;
        end
        KICK_ARMED: begin
          state_d = KICK_IDLE;
          if (kick_in == KEY1) kick_ok  = 1'b1;
          else                 key_viol = 1'b1;
        end
        default: state_d = KICK_IDLE;
      endcase
    end
  end

  assign win_viol   = kick_ok & (counter_q < window_q);
  assign kick_valid = kick_ok & ~win_viol;
  assign violation  = key_viol | win_viol;
  assign overflow   = tick & ~kick_valid & ~reset_cycle & (&counter_q);
  assign warn_hit   = tick & ~kick_valid & ~reset_cycle & ~(&counter_q) & (counter_inc == WARN_VAL);

  // Next values for counter, reload, window and config: a kick beats a tick,
  // byte writes override per lane, and a reset cycle reloads and records causes.
  always_comb begin
    counter_d = counter_q;
    reload_d  = reload_q;
    window_d  = window_q;
    cfg_d     = cfg_q;

    if (kick_valid)    counter_d = reload_q;
    else if (overflow) counter_d = reload_q;
    else if (tick)     counter_d = counter_inc;

    for (int i = 0; i < LANES; i++) begin
      if (counter_write[i]) counter_d[8*i +: 8] = counter_in[8*i +: 8];
      if (!locked && reload_write[i]) reload_d[8*i +: 8] = reload_in[8*i +: 8];
      if (!locked && window_write[i]) window_d[8*i +: 8] = window_in[8*i +: 8];
    end

    if (reset_cycle) begin
      counter_d = reload_q;
      if (!locked)     cfg_d[CFG_EN]   = 1'b0;
      if (fire_ovf_q)  cfg_d[CFG_OVF]  = 1'b1;
      if (fire_viol_q) cfg_d[CFG_VIOL] = 1'b1;
      if (trap)        cfg_d[CFG_TRAP] = 1'b1;
    end else if (config_write) begin
      cfg_d[CFG_EN]   = config_in[CFG_EN] | (locked & cfg_q[CFG_EN]);
      cfg_d[CFG_WIRQ] = config_in[CFG_WIRQ];
      cfg_d[CFG_LOCK] = config_in[CFG_LOCK] | locked;
      if (config_in[CFG_OVF])   cfg_d[CFG_OVF]   = 1'b0;
      if (config_in[CFG_TRAP])  cfg_d[CFG_TRAP]  = 1'b0;
      if (config_in[CFG_VIOL])  cfg_d[CFG_VIOL]  = 1'b0;
      if (config_in[CFG_WPEND]) cfg_d[CFG_WPEND] = 1'b0;
    end

    if (warn_hit) cfg_d[CFG_WPEND] = 1'b1;
    cfg_d[7] = 1'b0;
  end

  // Register update; power-on reset clears everything including the lock.
  always_ff @(posedge clk) begin
    if (power_on_reset) begin
      counter_q   <= '0;
      reload_q    <= '0;
      window_q    <= '0;
      cfg_q       <= '0;
      fire_q      <= 1'b0;
      fire_ovf_q  <= 1'b0;
      fire_viol_q <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      reload_q    <= reload_d;
      window_q    <= window_d;
      cfg_q       <= cfg_d;
      fire_q      <= overflow | violation;
      fire_ovf_q  <= overflow;
      fire_viol_q <= violation;
    end
  end

  assign reset       = power_on_reset | fire_q | trap;
  assign irq         = cfg_q[CFG_WPEND] & cfg_q[CFG_WIRQ];
  assign counter_out = counter_q;
  assign reload_out  = reload_q;
  assign window_out  = window_q;
  assign config_out  = cfg_q;

endmodule

// File: tb/tb_watchdog_window.sv
// Directed self-checking bench for watchdog_window with default parameters.
module tb_watchdog_window;

  localparam int SEL_COUNTER = 0;
  localparam int SEL_RELOAD  = 1;
  localparam int SEL_WINDOW  = 2;
  localparam int SEL_KICK    = 3;
  localparam int SEL_CONFIG  = 4;

  logic        clk = 1'b0;
  logic        power_on_reset, trap, reset, irq;
  logic [15:0] counter_in, counter_out, reload_in, reload_out, window_in, window_out;
  logic [1:0]  counter_write, reload_write, window_write;
  logic [7:0]  kick_in, config_in, config_out;
  logic        kick_write, config_write;

  int checks   = 0;
  int failures = 0;

  watchdog_window dut (
    .clk           (clk),
    .power_on_reset(power_on_reset),
    .trap          (trap),
    .reset         (reset),
    .irq           (irq),
    .counter_in    (counter_in),
    .counter_write (counter_write),
    .counter_out   (counter_out),
    .reload_in     (reload_in),
    .reload_write  (reload_write),
    .reload_out    (reload_out),
    .window_in     (window_in),
    .window_write  (window_write),
    .window_out    (window_out),
    .kick_in       (kick_in),
    .kick_write    (kick_write),
    .config_in     (config_in),
    .config_write  (config_write),
    .config_out    (config_out)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle register bus access: strobe held across exactly one rising edge.
  task automatic applyStimulus(input int sel, input logic [15:0] data, input logic [1:0] strobe);
    case (sel)
      SEL_COUNTER: begin counter_in = data; counter_write = strobe; end
      SEL_RELOAD:  begin reload_in  = data; reload_write  = strobe; end
      SEL_WINDOW:  begin window_in  = data; window_write  = strobe; end
      SEL_KICK:    begin kick_in    = data[7:0]; kick_write   = 1'b1; end
      default:     begin config_in  = data[7:0]; config_write = 1'b1; end
    endcase
    step(1);
    counter_write = '0;
    reload_write  = '0;
    window_write  = '0;
    kick_write    = 1'b0;
    config_write  = 1'b0;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    power_on_reset = 1'b1;
    trap           = 1'b0;
    counter_in     = '0;
    reload_in      = '0;
    window_in      = '0;
    counter_write  = '0;
    reload_write   = '0;
    window_write   = '0;
    kick_in        = '0;
    kick_write     = 1'b0;
    config_in      = '0;
    config_write   = 1'b0;

    // Power-on reset
    step(2);
    checkOutput("por_reset_out", {31'd0, reset}, 32'd1);
    checkOutput("por_irq", {31'd0, irq}, 32'd0);
    power_on_reset = 1'b0;
    step(1);
    checkOutput("por_counter", {16'd0, counter_out}, 32'h0000);
    checkOutput("por_config", {24'd0, config_out}, 32'h00);
    checkOutput("por_reload", {16'd0, reload_out}, 32'h0000);
    checkOutput("por_window", {16'd0, window_out}, 32'h0000);
    checkOutput("post_por_reset", {31'd0, reset}, 32'd0);

    // Overflow after four ticks of 16 clocks
    $display("[TB] overflow sequence");
    applyStimulus(SEL_RELOAD, 16'hFFFC, 2'b11);
    applyStimulus(SEL_COUNTER, 16'hFFFC, 2'b11);
    applyStimulus(SEL_CONFIG, 16'h0001, 2'b00);
    checkOutput("ovf_cfg_enabled", {24'd0, config_out}, 32'h01);
    step(16);
    checkOutput("ovf_first_tick", {16'd0, counter_out}, 32'hFFFD);
    step(47);
    checkOutput("ovf_before_fire", {31'd0, reset}, 32'd0);
    checkOutput("ovf_all_ones", {16'd0, counter_out}, 32'hFFFF);
    step(1);
    checkOutput("ovf_reset_pulse", {31'd0, reset}, 32'd1);
    checkOutput("ovf_reloaded", {16'd0, counter_out}, 32'hFFFC);
    step(1);
    checkOutput("ovf_pulse_one_cycle", {31'd0, reset}, 32'd0);
    checkOutput("ovf_cause", {24'd0, config_out}, 32'h02);

    // Early kick is a window violation
    $display("[TB] window violation");
    applyStimulus(SEL_WINDOW, 16'h8000, 2'b11);
    applyStimulus(SEL_COUNTER, 16'h1000, 2'b11);
    applyStimulus(SEL_CONFIG, 16'h0003, 2'b00);
    checkOutput("win_cfg_w1c", {24'd0, config_out}, 32'h01);
    applyStimulus(SEL_KICK, 16'h005A, 2'b00);
    checkOutput("win_armed_no_reset", {31'd0, reset}, 32'd0);
    applyStimulus(SEL_KICK, 16'h00A5, 2'b00);
    checkOutput("win_reset_pulse", {31'd0, reset}, 32'd1);
    step(1);
    checkOutput("win_cause", {24'd0, config_out}, 32'h08);
    checkOutput("win_counter_reload", {16'd0, counter_out}, 32'hFFFC);

    // Kick inside the window reloads the counter
    $display("[TB] valid kick");
    applyStimulus(SEL_CONFIG, 16'h0009, 2'b00);
    applyStimulus(SEL_COUNTER, 16'h9000, 2'b11);
    checkOutput("kick_counter_written", {16'd0, counter_out}, 32'h9000);
    applyStimulus(SEL_KICK, 16'h005A, 2'b00);
    applyStimulus(SEL_KICK, 16'h00A5, 2'b00);
    checkOutput("kick_no_reset", {31'd0, reset}, 32'd0);
    checkOutput("kick_counter_reload", {16'd0, counter_out}, 32'hFFFC);
    checkOutput("kick_cfg", {24'd0, config_out}, 32'h01);

    // Wrong second key
    $display("[TB] key violation");
    applyStimulus(SEL_KICK, 16'h005A, 2'b00);
    applyStimulus(SEL_KICK, 16'h0033, 2'b00);
    checkOutput("key_reset_pulse", {31'd0, reset}, 32'd1);
    step(1);
    checkOutput("key_cause", {24'd0, config_out}, 32'h08);

    // Early-warning interrupt
    $display("[TB] warning interrupt");
    applyStimulus(SEL_COUNTER, 16'hFFEE, 2'b11);
    applyStimulus(SEL_CONFIG, 16'h0019, 2'b00);
    checkOutput("warn_cfg", {24'd0, config_out}, 32'h11);
    checkOutput("warn_irq_low", {31'd0, irq}, 32'd0);
    step(32);
    checkOutput("warn_counter", {16'd0, counter_out}, 32'hFFF0);
    checkOutput("warn_irq_high", {31'd0, irq}, 32'd1);
    checkOutput("warn_pending", {24'd0, config_out}, 32'h51);
    applyStimulus(SEL_CONFIG, 16'h0051, 2'b00);
    checkOutput("warn_cleared_cfg", {24'd0, config_out}, 32'h11);
    checkOutput("warn_irq_dropped", {31'd0, irq}, 32'd0);

    // Lock behaviour and trap
    $display("[TB] lock and trap");
    applyStimulus(SEL_CONFIG, 16'h0021, 2'b00);
    checkOutput("lock_set", {24'd0, config_out}, 32'h21);
    applyStimulus(SEL_CONFIG, 16'h0000, 2'b00);
    checkOutput("lock_holds", {24'd0, config_out}, 32'h21);
    applyStimulus(SEL_RELOAD, 16'h1111, 2'b11);
    checkOutput("lock_reload_ignored", {16'd0, reload_out}, 32'hFFFC);
    applyStimulus(SEL_COUNTER, 16'h1234, 2'b11);
    checkOutput("lock_counter_write", {16'd0, counter_out}, 32'h1234);
    trap = 1'b1;
    #1;
    checkOutput("trap_reset_comb", {31'd0, reset}, 32'd1);
    step(1);
    trap = 1'b0;
    #1;
    checkOutput("trap_cfg", {24'd0, config_out}, 32'h25);
    checkOutput("trap_counter_reload", {16'd0, counter_out}, 32'hFFFC);
    checkOutput("trap_reset_released", {31'd0, reset}, 32'd0);

    // Single byte lane write
    applyStimulus(SEL_COUNTER, 16'h00AB, 2'b01);
    checkOutput("lane_write_low", {16'd0, counter_out}, 32'hFFAB);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
